// File: rtl/clk_tick_pkg.sv
// rtl/clk_tick_pkg.sv - shared constants and helpers for the tick generator
package clk_tick_pkg;

  localparam int DEFAULT_DIV_BOARD = 100000;
  localparam int DEFAULT_DIV_SIM   = 4;
  localparam int MAX_W             = 32;

  function automatic int chan_bits(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // A programmed divisor of 0 behaves exactly like 1.
  function automatic logic [MAX_W-1:0] eff_div(input logic [MAX_W-1:0] div);
    return (div == '0) ? MAX_W'(1) : div;
  endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// rtl/clk_tick_chan.sv - one modulo-divider channel with shadowed divisor reload
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int W           = 24,
  parameter int DEFAULT_DIV = DEFAULT_DIV_BOARD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_div,
  output logic         tick,
  output logic         sq,
  output logic         pending
);

  logic [W-1:0]     cnt;
  logic [W-1:0]     act_div;
  logic [W-1:0]     shd_div;
  logic [W-1:0]     eff;
  logic [MAX_W-1:0] eff_full;
  logic             wrap;

  assign eff_full = eff_div(MAX_W'(act_div));
  assign eff      = eff_full[W-1:0];
  assign wrap     = en & (cnt == eff - W'(1));

  generate
    if (W < MAX_W) begin : g_unused
      logic unused_eff_hi;
      assign unused_eff_hi = ^eff_full[MAX_W-1:W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      act_div <= W'(DEFAULT_DIV);
      shd_div <= W'(DEFAULT_DIV);
      pending <= 1'b0;
      sq      <= 1'b0;
      tick    <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      sq      <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      if (load) begin
        act_div <= load_div;
        shd_div <= load_div;
      end else if (pending) begin
        act_div <= shd_div;
      end
    end else begin
      tick <= wrap;
      if (wrap) begin
        cnt <= '0;
        sq  <= ~sq;
      end else if (en) begin
        cnt <= cnt + W'(1);
      end
      // Swaps happen only at a wrap, so the running period always finishes on the old divisor.
      if (load) begin
        shd_div <= load_div;
        if (wrap) act_div <= load_div;
        else      pending <= 1'b1;
      end else if (wrap && pending) begin
        act_div <= shd_div;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - multi-channel programmable tick/square-wave timebase
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int W           = 24,
  parameter int DEFAULT_DIV = DEFAULT_DIV_BOARD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          clear,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [chan_bits(NCH)-1:0]     cfg_chan,
  input  logic [W-1:0]                  cfg_div,
  output logic [NCH-1:0]                tick,
  output logic [NCH-1:0]                sq,
  output logic [NCH-1:0]                pending
);

  localparam int CHW = chan_bits(NCH);

  logic [NCH-1:0] load;

  // Out-of-range channel numbers match no slot, so they are never ready.
  always_comb begin
    cfg_ready = 1'b0;
    load      = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_chan == CHW'(i)) cfg_ready = ~pending[i];
    end
    for (int i = 0; i < NCH; i++) begin
      load[i] = cfg_valid & cfg_ready & (cfg_chan == CHW'(i));
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chan
      clk_tick_chan #(
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (clear),
        .load     (load[g]),
        .load_div (cfg_div),
        .tick     (tick[g]),
        .sq       (sq[g]),
        .pending  (pending[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb/tb_clk_tick_gen.sv - directed vector bench for clk_tick_gen
module tb_clk_tick_gen;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           clear;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_chan;
  logic [W-1:0]   cfg_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
  logic [NCH-1:0] pending;

  clk_tick_gen #(.NCH(NCH), .W(W), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clear     (clear),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic           clr;
    logic           vld;
    logic [CHW-1:0] ch;
    logic [W-1:0]   div;
    logic           rdy;
    logic [NCH-1:0] t;
    logic [NCH-1:0] s;
    logic [NCH-1:0] p;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void add(input logic e, input logic c, input logic v, input logic [CHW-1:0] ch,
                              input logic [W-1:0] d, input logic r, input logic [NCH-1:0] t,
                              input logic [NCH-1:0] s, input logic [NCH-1:0] p);
    vec_t x;
    x.en = e; x.clr = c; x.vld = v; x.ch = ch; x.div = d;
    x.rdy = r; x.t = t; x.s = s; x.p = p;
    tbl.push_back(x);
  endfunction

  task automatic drive(input logic e, input logic c, input logic v, input logic [CHW-1:0] ch,
                       input logic [W-1:0] d);
    en = e; clear = c; cfg_valid = v; cfg_chan = ch; cfg_div = d;
    #1;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_t;
    int second_t;
    reset = 1'b1;
    drive(1, 0, 0, 0, 0);
    edge1();
    edge1();
    chk("reset_tick", int'(tick), 0);
    chk("reset_sq", int'(sq), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_ready", int'(cfg_ready), 1);
    reset = 1'b0;

    // Div 4 on all channels; ch0 reload to 6 at cnt=1, then a write of 3 coincident with a wrap.
    add(1,0,0,0,0, 1, 3'b000, 3'b000, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b000, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b000, 3'b000);
    add(1,0,0,0,0, 1, 3'b111, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b111, 3'b000, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b000, 3'b000);
    add(1,0,1,0,6, 1, 3'b000, 3'b000, 3'b001);
    add(1,0,0,0,0, 0, 3'b000, 3'b000, 3'b001);
    add(1,0,0,0,0, 0, 3'b111, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b110, 3'b001, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b001, 3'b000);
    add(1,0,0,0,0, 1, 3'b001, 3'b000, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b000, 3'b000);
    add(1,0,0,0,0, 1, 3'b110, 3'b110, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b110, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b110, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b110, 3'b000);
    add(1,0,1,0,3, 1, 3'b111, 3'b001, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b001, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b001, 3'b000);
    add(1,0,0,0,0, 1, 3'b001, 3'b000, 3'b000);
    add(1,0,0,0,0, 1, 3'b110, 3'b110, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b110, 3'b000);
    add(1,0,0,0,0, 1, 3'b001, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b000, 3'b111, 3'b000);
    add(1,0,0,0,0, 1, 3'b110, 3'b001, 3'b000);
    add(1,0,0,0,0, 1, 3'b001, 3'b000, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].ch, tbl[i].div);
      chk($sformatf("v%0d_ready", i + 1), int'(cfg_ready), int'(tbl[i].rdy));
      edge1();
      chk($sformatf("v%0d_tick", i + 1), int'(tick), int'(tbl[i].t));
      chk($sformatf("v%0d_sq", i + 1), int'(sq), int'(tbl[i].s));
      chk($sformatf("v%0d_pending", i + 1), int'(pending), int'(tbl[i].p));
    end

    // en low for 5 cycles freezes counters; ch0 (div 3) and ch1/2 (div 4) resume where they were.
    drive(1, 0, 0, 0, 0);
    edge1();
    chk("en_pre_tick", int'(tick), 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk($sformatf("en_off%0d_tick", i), int'(tick), 0);
      chk($sformatf("en_off%0d_sq", i), int'(sq), 0);
    end
    drive(1, 0, 0, 0, 0);
    edge1();
    chk("en_resume1_tick", int'(tick), 0);
    edge1();
    chk("en_resume2_tick", int'(tick), 3'b111);
    chk("en_resume2_sq", int'(sq), 3'b111);

    // Clear applies a pending divisor of 2 immediately.
    drive(1, 0, 1, 0, 2);
    chk("clr_wr_ready", int'(cfg_ready), 1);
    edge1();
    chk("clr_wr_pending", int'(pending), 3'b001);
    drive(1, 1, 0, 0, 0);
    edge1();
    chk("clr_tick", int'(tick), 0);
    chk("clr_sq", int'(sq), 0);
    chk("clr_pending", int'(pending), 0);
    drive(1, 0, 0, 0, 0);
    begin
      logic [NCH-1:0] exp_t[6];
      logic           exp_s0[6];
      exp_t  = '{3'b000, 3'b001, 3'b000, 3'b111, 3'b000, 3'b001};
      exp_s0 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
        edge1();
        chk($sformatf("div2_e%0d_tick", i + 1), int'(tick), int'(exp_t[i]));
        chk($sformatf("div2_e%0d_sq0", i + 1), int'(sq[0]), int'(exp_s0[i]));
      end
    end

    // Divisors 0 and 1, loaded together with clear, tick every enabled cycle.
    for (int d = 0; d < 2; d++) begin
      drive(1, 1, 1, 0, W'(d));
      chk($sformatf("div%0d_ready", d), int'(cfg_ready), 1);
      edge1();
      chk($sformatf("div%0d_clr_pending", d), int'(pending), 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        edge1();
        chk($sformatf("div%0d_e%0d_tick0", d, i + 1), int'(tick[0]), 1);
        chk($sformatf("div%0d_e%0d_sq0", d, i + 1), int'(sq[0]), (i % 2 == 0) ? 1 : 0);
      end
    end

    // Maximum divisor for W=8.
    drive(1, 1, 1, 0, 8'd255);
    edge1();
    drive(1, 0, 0, 0, 0);
    first_t  = -1;
    second_t = -1;
    for (int i = 1; i <= 600 && second_t < 0; i++) begin
      edge1();
      if (tick[0]) begin
        if (first_t < 0) first_t = i;
        else             second_t = i;
      end
    end
    chk("div255_first_tick", first_t, 255);
    chk("div255_second_tick", second_t, 510);

    // Invalid channel is never ready and changes nothing.
    drive(1, 1, 0, 0, 0);
    edge1();
    drive(1, 0, 1, 3, 7);
    chk("badch_ready", int'(cfg_ready), 0);
    edge1();
    chk("badch_pending", int'(pending), 0);

    // Reset while ch1 is pending discards the write and restores the default divisor.
    drive(1, 1, 0, 0, 0);
    edge1();
    drive(1, 0, 1, 1, 9);
    chk("rst_wr_ready", int'(cfg_ready), 1);
    edge1();
    chk("rst_wr_pending", int'(pending), 3'b010);
    drive(1, 0, 0, 1, 0);
    chk("rst_ch1_busy", int'(cfg_ready), 0);
    reset = 1'b1;
    edge1();
    chk("rst_pending", int'(pending), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_sq", int'(sq), 0);
    reset = 1'b0;
    #1;
    chk("rst_ch1_ready", int'(cfg_ready), 1);
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk($sformatf("rst_e%0d_tick", i + 1), int'(tick), (i == 3) ? 7 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
